// File: rtl/hdmi_text_pkg.sv
// Shared constants and state types for the text-mode VRAM AXI4-Lite slave.
// A character byte is {inv, glyph[6:0]}, packed four per 32-bit word.
package hdmi_text_pkg;

  localparam logic [9:0] VRAM_WORDS  = 10'd600;
  localparam logic [9:0] CTRL_INDEX  = 10'd600;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_MEM, R_DATA} rd_state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_VRAM, SRC_CTRL} rd_src_t;

  function automatic logic [1:0] wr_resp(input logic [9:0] idx);
    return ((idx < VRAM_WORDS) || (idx == CTRL_INDEX)) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/hdmi_text_axi_vram_bram.sv
// 600x32 dual-port RAM: byte-write port A, registered read-only port B.
// Port B is read-first against a same-cycle port A write and returns 0 out of range.
module vram_dp_bram
  import hdmi_text_pkg::*;
(
  input  logic        clk,
  input  logic        i_a_we,
  input  logic [3:0]  i_a_be,
  input  logic [9:0]  i_a_addr,
  input  logic [31:0] i_a_wdata,
  input  logic        i_b_en,
  input  logic [9:0]  i_b_addr,
  output logic [31:0] o_b_rdata
);

  logic [31:0] r_mem [0:VRAM_WORDS-1];
  logic [31:0] r_b_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; contents start undefined.
  always_ff @(posedge clk) begin
    if (i_a_we) begin
      for (int k = 0; k < 4; k++) begin
        if (i_a_be[k]) r_mem[i_a_addr][8*k +: 8] <= i_a_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_b_en) r_b_rdata <= (i_b_addr < VRAM_WORDS) ? r_mem[i_b_addr] : '0;
  end

  assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/hdmi_text_axi_vram.sv
// AXI4-Lite slave holding the character VRAM and control word for the text pixel stage.
// The RAM is kept as two identical copies so AXI reads and video reads never contend.
module hdmi_text_axi_vram
  import hdmi_text_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [9:0]                      vid_word_addr,
  output logic [31:0]                     vid_word_data,
  output logic [31:0]                     ctrl_data
);

  wr_state_t   r_wstate;
  logic        r_awready, r_wready, r_bvalid, r_commit;
  logic [1:0]  r_bresp;
  logic [9:0]  r_aw_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_ctrl;

  rd_state_t   r_rstate;
  rd_src_t     r_rd_src;
  logic        r_arready, r_rvalid;
  logic [1:0]  r_rresp;
  logic [9:0]  r_rd_idx;
  logic [31:0] r_rd_ctrl;

  logic        w_aw_hs, w_w_hs, w_vram_we, w_ctrl_we;
  logic [9:0]  w_aw_idx;
  logic [31:0] w_axi_rdata, w_rdata;
  logic        w_unused_addr_lsbs;

  assign w_aw_hs  = S_AXI_AWVALID && r_awready;
  assign w_w_hs   = S_AXI_WVALID  && r_wready;
  assign w_aw_idx = S_AXI_AWADDR[11:2];
  assign w_unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_commit  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_commit <= 1'b0;
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          if (w_aw_hs) r_aw_idx <= w_aw_idx;
          if (w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
          end
          if (w_aw_hs && w_w_hs) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= wr_resp(w_aw_idx);
            r_commit  <= 1'b1;
          end else if (w_aw_hs) begin
            r_wstate  <= W_GOT_AW;
            r_awready <= 1'b0;
          end else if (w_w_hs) begin
            r_wstate <= W_GOT_W;
            r_wready <= 1'b0;
          end
        end
        W_GOT_AW: begin
          if (w_w_hs) begin
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
            r_wstate <= W_RESP;
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= wr_resp(r_aw_idx);
            r_commit <= 1'b1;
          end
        end
        W_GOT_W: begin
          if (w_aw_hs) begin
            r_aw_idx  <= w_aw_idx;
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= wr_resp(w_aw_idx);
            r_commit  <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // The commit cycle is the first W_RESP cycle; r_commit drops at once on reset.
  assign w_vram_we = r_commit && (r_aw_idx < VRAM_WORDS);
  assign w_ctrl_we = r_commit && (r_aw_idx == CTRL_INDEX);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_ctrl <= '0;
    end else if (w_ctrl_we) begin
      for (int k = 0; k < 4; k++) begin
        if (r_wstrb[k]) r_ctrl[8*k +: 8] <= r_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rd_idx  <= '0;
      r_rd_src  <= SRC_ZERO;
      r_rd_ctrl <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (S_AXI_ARVALID && r_arready) begin
            r_rd_idx  <= S_AXI_ARADDR[11:2];
            r_arready <= 1'b0;
            r_rstate  <= R_MEM;
          end
        end
        R_MEM: begin
          r_rstate  <= R_DATA;
          r_rvalid  <= 1'b1;
          r_rd_ctrl <= r_ctrl;
          if (r_rd_idx < VRAM_WORDS) begin
            r_rd_src <= SRC_VRAM;
            r_rresp  <= RESP_OKAY;
          end else if (r_rd_idx == CTRL_INDEX) begin
            r_rd_src <= SRC_CTRL;
            r_rresp  <= RESP_OKAY;
          end else begin
            r_rd_src <= SRC_ZERO;
            r_rresp  <= RESP_SLVERR;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // NOTE: the default assignment first keeps this combinational mux from inferring a latch.
  always_comb begin
    w_rdata = '0;
    case (r_rd_src)
      SRC_VRAM: w_rdata = w_axi_rdata;
      SRC_CTRL: w_rdata = r_rd_ctrl;
      default:  w_rdata = '0;
    endcase
  end

  vram_dp_bram u_vram_vid (
    .clk       (S_AXI_ACLK),
    .i_a_we    (w_vram_we),
    .i_a_be    (r_wstrb),
    .i_a_addr  (r_aw_idx),
    .i_a_wdata (r_wdata),
    .i_b_en    (1'b1),
    .i_b_addr  (vid_word_addr),
    .o_b_rdata (vid_word_data)
  );

  // Enabled only in R_MEM so the word stays held while RREADY is low.
  vram_dp_bram u_vram_axi (
    .clk       (S_AXI_ACLK),
    .i_a_we    (w_vram_we),
    .i_a_be    (r_wstrb),
    .i_a_addr  (r_aw_idx),
    .i_a_wdata (r_wdata),
    .i_b_en    (r_rstate == R_MEM),
    .i_b_addr  (r_rd_idx),
    .o_b_rdata (w_axi_rdata)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = w_rdata;
  assign ctrl_data     = r_ctrl;

endmodule

// File: tb/tb_hdmi_text_axi_vram.sv
// Scoreboard bench for hdmi_text_axi_vram: AXI responses are queued at issue and
// checked by a monitor on each B/R handshake; timing and video reads are checked inline.
module tb_hdmi_text_axi_vram;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, vid_data, ctrl;
  logic [9:0]  vid_addr = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [1:0]  q_b[$];
  rexp_t       q_r[$];
  logic [1:0]  e_b;
  rexp_t       e_r;
  logic [31:0] ctrl_at_b;
  int          n;

  hdmi_text_axi_vram dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .vid_word_addr (vid_addr),
    .vid_word_data (vid_data),
    .ctrl_data     (ctrl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits on negedges until a DUT condition holds; returns how many negedges it took.
  task automatic wait_cond(input int which, input string name, output int cnt);
    logic met;
    met = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 32 && !met; i++) begin
      @(negedge clk);
      cnt = i;
      case (which)
        0: met = awready && wready;
        1: met = awready;
        2: met = wready;
        3: met = arready;
        4: met = bvalid;
        default: met = rvalid;
      endcase
    end
    if (!met) check({name, "_timeout"}, 32'(met), 32'd1);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp);
    int c;
    q_b.push_back(exp_resp);
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    wait_cond(0, "aw_w_ready", c);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_cond(4, "bvalid", c);
    check("b_latency", 32'(c), 32'd1);
    ctrl_at_b = ctrl;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp);
    int c;
    rexp_t e;
    e.data = exp_d; e.resp = exp_resp;
    q_r.push_back(e);
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    wait_cond(3, "arready", c);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_cond(5, "rvalid", c);
    check("r_latency", 32'(c), 32'd2);
    @(posedge clk); #1;
  endtask

  task automatic vid_read(input logic [9:0] idx, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    vid_addr = idx;
    @(posedge clk);
    @(negedge clk);
    check(name, vid_data, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (q_b.size() == 0) check("b_unexpected", 32'(q_b.size()), 32'd1);
      else begin
        e_b = q_b.pop_front();
        check("bresp", {30'd0, bresp}, {30'd0, e_b});
      end
    end
    if (rst_n && rvalid && rready) begin
      if (q_r.size() == 0) check("r_unexpected", 32'(q_r.size()), 32'd1);
      else begin
        e_r = q_r.pop_front();
        check("rdata", rdata, e_r.data);
        check("rresp", {30'd0, rresp}, {30'd0, e_r.resp});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ctrl", ctrl, 32'd0);
    rst_n = 1'b1;

    // 1: AW and W together
    axi_write(12'h000, 32'h8341_4241, 4'hF, 2'b00);
    vid_read(10'd0, 32'h8341_4241, "t1_vid_word0");

    // 2: W three cycles ahead of AW, strobe 0101 over a zeroed word
    axi_write(12'h004, 32'h0000_0000, 4'hF, 2'b00);
    q_b.push_back(2'b00);
    @(posedge clk); #1;
    wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
    wait_cond(2, "t2_wready", n);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    check("t2_got_w_awready", {31'd0, awready}, 32'd1);
    check("t2_got_w_wready", {31'd0, wready}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    awaddr = 12'h004; awvalid = 1'b1;
    wait_cond(1, "t2_awready", n);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wait_cond(4, "t2_bvalid", n);
    check("t2_b_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    axi_read(12'h004, 32'h00BB_00DD, 2'b00);
    vid_read(10'd1, 32'h00BB_00DD, "t2_vid_word1");

    // 3: control register
    axi_write(12'h960, 32'h0012_3456, 4'hF, 2'b00);
    check("t3_ctrl_in_commit", ctrl_at_b, 32'd0);
    check("t3_ctrl_after", ctrl, 32'h0012_3456);
    axi_read(12'h960, 32'h0012_3456, 2'b00);

    // 4: out of range
    axi_write(12'hFFC, 32'hDEAD_BEEF, 4'hF, 2'b10);
    check("t4_ctrl_kept", ctrl, 32'h0012_3456);
    vid_read(10'd0, 32'h8341_4241, "t4_vid_word0_kept");
    axi_read(12'h964, 32'h0000_0000, 2'b10);
    axi_read(12'hFFC, 32'h0000_0000, 2'b10);
    vid_read(10'd700, 32'h0000_0000, "t4_vid_oob");

    // 5: backpressure on B and R
    bready = 1'b0; rready = 1'b0;
    q_b.push_back(2'b00);
    e_r.data = 32'h8341_4241; e_r.resp = 2'b00;
    q_r.push_back(e_r);
    @(posedge clk); #1;
    awaddr = 12'h008; wdata = 32'h1122_3344; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h000; arvalid = 1'b1;
    wait_cond(0, "t5_ready", n);
    check("t5_arready_idle", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_bvalid", {31'd0, bvalid}, 32'd1);
      check("t5_rvalid", {31'd0, rvalid}, 32'd1);
      check("t5_rdata", rdata, 32'h8341_4241);
      check("t5_awready", {31'd0, awready}, 32'd0);
      check("t5_wready", {31'd0, wready}, 32'd0);
      check("t5_arready", {31'd0, arready}, 32'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    vid_read(10'd2, 32'h1122_3344, "t5_vid_word2");

    // 6: same-cycle write/video read of word 5, then reset in W_GOT_AW
    axi_write(12'h014, 32'h0000_0007, 4'hF, 2'b00);
    q_b.push_back(2'b00);
    @(posedge clk); #1;
    vid_addr = 10'd5;
    awaddr = 12'h014; wdata = 32'h0000_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_cond(0, "t6_ready", n);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t6_bvalid", {31'd0, bvalid}, 32'd1);
    @(negedge clk);
    check("t6_vid_read_first", vid_data, 32'h0000_0007);
    @(negedge clk);
    check("t6_vid_new", vid_data, 32'h0000_0001);

    @(posedge clk); #1;
    awaddr = 12'h00C; awvalid = 1'b1;
    wait_cond(1, "t6_awready", n);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("t6_got_aw_awready", {31'd0, awready}, 32'd0);
    check("t6_got_aw_wready", {31'd0, wready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_awready", {31'd0, awready}, 32'd0);
    check("t6_rst_wready", {31'd0, wready}, 32'd0);
    check("t6_rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("t6_rst_arready", {31'd0, arready}, 32'd0);
    check("t6_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("t6_rst_bresp", {30'd0, bresp}, 32'd0);
    check("t6_rst_rresp", {30'd0, rresp}, 32'd0);
    check("t6_rst_rdata", rdata, 32'd0);
    check("t6_rst_ctrl", ctrl, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    axi_write(12'h00C, 32'h5A5A_5A5A, 4'hF, 2'b00);
    axi_read(12'h00C, 32'h5A5A_5A5A, 2'b00);
    axi_read(12'h014, 32'h0000_0001, 2'b00);

    repeat (3) @(posedge clk);
    check("b_queue_empty", 32'(q_b.size()), 32'd0);
    check("r_queue_empty", 32'(q_r.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_text_axi_vram.md
Name: hdmi_text_axi_vram

Overview:
AXI4-Lite slave that feeds the text-mode pixel stage. It holds the character VRAM (600 x 32-bit words; 80x30 characters, 4 per word) and the control register. Every character byte is {inv, glyph[6:0]}, with byte k of a word at bits [8k+7:8k]. The AXI side writes and reads the VRAM and control register. The video side gets a 1-cycle-latency read port plus the live control word.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 12, AXI byte address width.
VRAM_WORDS, 600, number of VRAM words (word indices 0..599).
CTRL_INDEX, 600, word index of the control register (byte address 0x960).

Ports:
S_AXI_ACLK  in  1  the single clock
S_AXI_ARESETN  in  1  asynchronous reset, active-low
S_AXI_AWADDR  in  12  write address (byte)
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
S_AXI_ARADDR  in  12  read address (byte)
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
vid_word_addr  in  10  video-side VRAM word index
vid_word_data  out  32  VRAM word, 1 cycle after vid_word_addr
ctrl_data  out  32  control register, registered and always valid

Behaviour:
- Reset (asynchronous, ARESETN=0):
  - AWREADY, WREADY, BVALID, ARREADY and RVALID are 0.
  - BRESP, RRESP, RDATA and ctrl_data are 0.
  - Both state machines return to IDLE. VRAM contents are not reset.
  - Reset mid-transaction abandons the transaction with no memory write.
- Word index = addr[11:2]; addr[1:0] is ignored.
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - W_IDLE: AWREADY=WREADY=1.
    - AW and W handshake together: go to W_RESP.
    - Only AW handshakes: go to W_GOT_AW. Only W handshakes: go to W_GOT_W.
  - W_GOT_AW: AWREADY=0, WREADY=1; wait for W. W_GOT_W: the mirror case.
  - Address and data are latched at their respective handshakes.
  - The memory write commits on the cycle of entry into W_RESP. Byte k is written only if WSTRB[k]=1.
  - Targets:
    - Index < VRAM_WORDS: VRAM; BRESP=OKAY (00).
    - Index == CTRL_INDEX: control register; BRESP=OKAY.
    - Any other index: no write; BRESP=SLVERR (10).
  - W_RESP: BVALID=1, held until BREADY. The handshake returns to W_IDLE. No new AW/W is accepted while BVALID=1.
- Read FSM states: R_IDLE, R_MEM, R_DATA.
  - R_IDLE: ARREADY=1. The AR handshake latches the index and goes to R_MEM (array access cycle).
  - R_MEM goes to R_DATA with RVALID=1.
  - RDATA source:
    - VRAM word for indices < VRAM_WORDS.
    - ctrl_data for CTRL_INDEX.
    - 0 with RRESP=SLVERR for any other index.
  - RDATA and RVALID are held until RREADY; the handshake returns to R_IDLE.
  - Latency from AR handshake to RVALID is 2 cycles.
- Concurrency:
  - The read and write channels are independent and may be active in the same cycle.
  - AXI read access and write commit to the same word in one cycle: the read returns the pre-write data (read-first).
- Video port:
  - Separate read port on a true dual-port RAM.
  - vid_word_data equals mem[vid_word_addr] registered, with 1-cycle latency.
  - Read-first against a same-cycle AXI write.
  - vid_word_addr >= VRAM_WORDS returns 0.
- ctrl_data updates on the cycle after the control-register write commit.

Decomposition:
- Package hdmi_text_pkg:
  - Constants VRAM_WORDS, CTRL_INDEX, RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Enums wr_state_t and rd_state_t.
- Sub-module vram_dp_bram:
  - 600x32 true dual port, byte-write port A, read-only port B.
  - Both ports registered and read-first; infers block RAM.

Test Plan:
1. Reset, AW/W together:
   - Stimulus: after reset, AWADDR=0x000, WDATA=0x8341_4241, WSTRB=F, both valid in the same cycle.
   - Required: BVALID exactly one cycle later with BRESP=00. vid_word_addr=0 then gives 0x83414241 one cycle later.
2. W before AW, partial strobe:
   - Stimulus: W arrives 3 cycles before AW; address 0x004, WDATA=0xAABBCCDD, WSTRB=0101, word previously 0.
   - Required: the word reads back 0x00BB00DD.
3. Control register:
   - Stimulus: write 0x0012_3456 to 0x960.
   - Required: ctrl_data=0x00123456 one cycle after commit. AXI read of 0x960 returns the same value with RRESP=00, RVALID 2 cycles after AR.
4. Out of range:
   - Write 0xFFC: BRESP=10 and no memory change.
   - Read 0x964: RDATA=0, RRESP=10.
5. Backpressure:
   - Stimulus: hold BREADY=0 and RREADY=0 for 5 cycles.
   - Required: BVALID, RVALID and RDATA stable; AWREADY=WREADY=0 and ARREADY=0 throughout.
6. Same-cycle collision and reset:
   - Stimulus: write 0x1 to word 5 (old value 0x7) while the video port reads word 5 in the commit cycle.
   - Required: vid_word_data=0x7 that cycle and 0x1 on the next read.
   - Then assert ARESETN=0 in W_GOT_AW: all outputs drop to 0 immediately.
